// File: rtl/siphash_pkg.sv
// -----------------------------------------------------------------------------
// siphash_pkg
//   Shared definitions for the SipHash message formatter:
//   - fmt_state_e        : formatter FSM state encoding
//   - SIPHASH_WORD_BYTES : bytes per SipHash message word
//   - SIPHASH_LEN_LANE   : byte lane of the final word that carries the length
// -----------------------------------------------------------------------------
package siphash_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_INIT       = 3'd1,
      S_COLLECT    = 3'd2,
      S_COMP       = 3'd3,
      S_COMP_WAIT  = 3'd4,
      S_FINAL      = 3'd5,
      S_FINAL_WAIT = 3'd6
   } fmt_state_e;

   localparam int SIPHASH_WORD_BYTES = 8;
   localparam int SIPHASH_LEN_LANE   = 7;

endpackage

// File: rtl/siphash_byte_packer.sv
// -----------------------------------------------------------------------------
// siphash_byte_packer
//   Packs message bytes little-endian into a 64-bit word, tracks the lane
//   counter and the message length (mod 256), and presents the word the
//   formatter should hand to the core next.
// Ports:
//   clk, areset   : clock, asynchronous active-high reset
//   clr_i         : clear buffer, lane counter and length (new hash / abort)
//   clr_word_i    : clear buffer and lane counter (start of next word)
//   wr_i, data_i  : write one byte into the current lane
//   last_i        : the byte being written is the final message byte
//   form_pad_i    : present the pad word {len, 56'h0} instead of the buffer
//   word_o        : word as it stands once the current byte is written
//   lane_last_o   : the next written byte fills the top lane
// -----------------------------------------------------------------------------
module siphash_byte_packer
   import siphash_pkg::*;
(
   input  logic        clk,
   input  logic        areset,
   input  logic        clr_i,
   input  logic        clr_word_i,
   input  logic        wr_i,
   input  logic [7:0]  data_i,
   input  logic        last_i,
   input  logic        form_pad_i,
   output logic [63:0] word_o,
   output logic        lane_last_o
);

   logic [63:0] buf_q, buf_d;
   logic [2:0]  ctr_q;
   logic [7:0]  len_q, len_d;

   assign lane_last_o = (ctr_q == 3'(SIPHASH_WORD_BYTES - 1));

   // The word is formed from the post-write view so the FSM can launch the
   // compress on the same edge that accepts the completing byte.
   always_comb begin
      buf_d = buf_q;
      buf_d[{ctr_q, 3'b000} +: 8] = data_i;
      len_d  = len_q + 8'd1;
      word_o = buf_d;
      if (form_pad_i) begin
         word_o = '0;
         word_o[8*SIPHASH_LEN_LANE +: 8] = len_q;
      end else if (last_i && !lane_last_o) begin
         // Short final word: length byte overlays the never-written top lane.
         word_o[8*SIPHASH_LEN_LANE +: 8] = len_d;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         buf_q <= '0;
         ctr_q <= '0;
         len_q <= '0;
      end else if (clr_i) begin
         buf_q <= '0;
         ctr_q <= '0;
         len_q <= '0;
      end else if (clr_word_i) begin
         buf_q <= '0;
         ctr_q <= '0;
      end else if (wr_i) begin
         buf_q <= buf_d;
         ctr_q <= ctr_q + 3'd1;
         len_q <= len_d;
      end
   end

endmodule

// File: rtl/siphash_msg_formatter.sv
// -----------------------------------------------------------------------------
// siphash_msg_formatter
//   Byte-stream front end for siphash_core: packs bytes into 64-bit words,
//   appends the length byte / padding and sequences initalize, compress and
//   finalize against the core's ready.
// Ports:
//   clk, areset            : clock, asynchronous active-high reset
//   start, empty_msg       : begin a hash (empty_msg = zero-length message)
//   in_valid/in_data/in_last/in_ready : byte stream, accepted on valid&ready
//   core_initalize/core_compress/core_finalize : one-cycle core strobes
//   core_mi                : message word, valid while core_compress = 1
//   core_ready             : core ready
//   busy, done             : hash in progress, one-cycle completion pulse
//   abort                  : only when SIPHASH_FMT_ABORT_EN is defined
// Build option: define SIPHASH_FMT_ABORT_EN to add the abort input and paths.
// -----------------------------------------------------------------------------
module siphash_msg_formatter
   import siphash_pkg::*;
(
   input  logic        clk,
   input  logic        areset,
   input  logic        start,
   input  logic        empty_msg,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        core_initalize,
   output logic        core_compress,
   output logic        core_finalize,
   output logic [63:0] core_mi,
   input  logic        core_ready,
`ifdef SIPHASH_FMT_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done
);

   fmt_state_e  state_q;
   logic        in_ready_q, init_q, comp_q, fin_q, busy_q, done_q;
   logic [63:0] mi_q;
   logic        empty_q, last_word_q, pad_pending_q;
`ifdef SIPHASH_FMT_ABORT_EN
   logic        drain_q;
   logic        abort_go;
`endif

   logic        accept, start_go;
   logic        pk_clr, pk_clr_word, pk_form_pad, pk_lane_last;
   logic [63:0] pk_word;

   assign in_ready       = in_ready_q;
   assign core_initalize = init_q;
   assign core_compress  = comp_q;
   assign core_finalize  = fin_q;
   assign core_mi        = mi_q;
   assign busy           = busy_q;
   assign done           = done_q;

   assign accept = in_valid & in_ready_q;

`ifdef SIPHASH_FMT_ABORT_EN
   assign start_go = start & ~abort;
   assign abort_go = abort & (state_q != S_IDLE);
   assign pk_clr   = ((state_q == S_IDLE) & start_go) | abort_go;
`else
   assign start_go = start;
   assign pk_clr   = (state_q == S_IDLE) & start_go;
`endif
   assign pk_clr_word = (state_q == S_COMP_WAIT) & core_ready & ~pad_pending_q & ~last_word_q;
   // Both pad sources ({len,56'h0}): empty message in INIT, 8-byte-aligned tail.
   assign pk_form_pad = (state_q == S_INIT) | ((state_q == S_COMP_WAIT) & pad_pending_q);

   siphash_byte_packer u_packer (
      .clk         (clk),
      .areset      (areset),
      .clr_i       (pk_clr),
      .clr_word_i  (pk_clr_word),
      .wr_i        (accept),
      .data_i      (in_data),
      .last_i      (in_last),
      .form_pad_i  (pk_form_pad),
      .word_o      (pk_word),
      .lane_last_o (pk_lane_last)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q       <= S_IDLE;
         in_ready_q    <= 1'b0;
         init_q        <= 1'b0;
         comp_q        <= 1'b0;
         fin_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mi_q          <= '0;
         empty_q       <= 1'b0;
         last_word_q   <= 1'b0;
         pad_pending_q <= 1'b0;
`ifdef SIPHASH_FMT_ABORT_EN
         drain_q       <= 1'b0;
`endif
      end else begin
         // Strobes are single-cycle unless re-armed below.
         init_q <= 1'b0;
         comp_q <= 1'b0;
         fin_q  <= 1'b0;
         done_q <= 1'b0;
`ifdef SIPHASH_FMT_ABORT_EN
         if (abort_go) begin
            in_ready_q    <= 1'b0;
            empty_q       <= 1'b0;
            last_word_q   <= 1'b0;
            pad_pending_q <= 1'b0;
            // A busy core must be drained before a new hash can be started.
            if (!core_ready) begin
               state_q <= S_FINAL_WAIT;
               drain_q <= 1'b1;
            end else begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               drain_q <= 1'b0;
            end
         end else
`endif
         begin
            case (state_q)
               S_IDLE: begin
                  if (start_go) begin
                     state_q       <= S_INIT;
                     busy_q        <= 1'b1;
                     init_q        <= 1'b1;
                     empty_q       <= empty_msg;
                     last_word_q   <= 1'b0;
                     pad_pending_q <= 1'b0;
                  end
               end
               S_INIT: begin
                  if (empty_q) begin
                     mi_q        <= pk_word;
                     comp_q      <= 1'b1;
                     last_word_q <= 1'b1;
                     state_q     <= S_COMP;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= S_COLLECT;
                  end
               end
               S_COLLECT: begin
                  if (accept && (in_last || pk_lane_last)) begin
                     in_ready_q <= 1'b0;
                     mi_q       <= pk_word;
                     comp_q     <= 1'b1;
                     state_q    <= S_COMP;
                     // A full final word still owes the core a length-only word.
                     if (pk_lane_last) pad_pending_q <= in_last;
                     else              last_word_q   <= 1'b1;
                  end
               end
               S_COMP: state_q <= S_COMP_WAIT;
               S_COMP_WAIT: begin
                  if (core_ready) begin
                     if (pad_pending_q) begin
                        mi_q          <= pk_word;
                        comp_q        <= 1'b1;
                        pad_pending_q <= 1'b0;
                        last_word_q   <= 1'b1;
                        state_q       <= S_COMP;
                     end else if (last_word_q) begin
                        fin_q   <= 1'b1;
                        state_q <= S_FINAL;
                     end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_COLLECT;
                     end
                  end
               end
               S_FINAL: state_q <= S_FINAL_WAIT;
               S_FINAL_WAIT: begin
                  if (core_ready) begin
`ifdef SIPHASH_FMT_ABORT_EN
                     done_q  <= ~drain_q;
                     drain_q <= 1'b0;
`else
                     done_q  <= 1'b1;
`endif
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_siphash_msg_formatter.sv
// -----------------------------------------------------------------------------
// tb_siphash_msg_formatter
//   Drives byte messages into siphash_msg_formatter against a behavioural
//   SipHash-2-4 core model (key 00..0f) with configurable ready latency.
//   Expected message words are queued when a message is launched and popped
//   on every core_compress.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_siphash_msg_formatter;

   localparam logic [63:0] K0 = 64'h0706050403020100;
   localparam logic [63:0] K1 = 64'h0f0e0d0c0b0a0908;

   logic        clk = 1'b0;
   logic        areset, start, empty_msg, in_valid, in_last;
   logic [7:0]  in_data;
   logic        in_ready, core_initalize, core_compress, core_finalize;
   logic [63:0] core_mi;
   logic        core_ready = 1'b1;
   logic        busy, done;
`ifdef SIPHASH_FMT_ABORT_EN
   logic        abort;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   int          lat = 0;
   int          lat_fix;
   bit          stall;
   logic [255:0] sv = '0;
   logic [63:0] core_res = '0;
   logic [63:0] exp_words[$];
   logic [7:0]  msg [0:299];

   always #5 clk = ~clk;

   siphash_msg_formatter dut (
      .clk            (clk),
      .areset         (areset),
      .start          (start),
      .empty_msg      (empty_msg),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .core_initalize (core_initalize),
      .core_compress  (core_compress),
      .core_finalize  (core_finalize),
      .core_mi        (core_mi),
      .core_ready     (core_ready),
`ifdef SIPHASH_FMT_ABORT_EN
      .abort          (abort),
`endif
      .busy           (busy),
      .done           (done)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- SipHash-2-4 reference core ----------------
   function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
      return (x << s) | (x >> (64 - s));
   endfunction

   function automatic logic [255:0] sip_rounds(input logic [255:0] v, input int n);
      logic [63:0] a, b, c, d;
      {a, b, c, d} = v;
      for (int i = 0; i < n; i++) begin
         a = a + b; b = rotl(b, 13); b ^= a; a = rotl(a, 32);
         c = c + d; d = rotl(d, 16); d ^= c;
         a = a + d; d = rotl(d, 21); d ^= a;
         c = c + b; b = rotl(b, 17); b ^= c; c = rotl(c, 32);
      end
      return {a, b, c, d};
   endfunction

   function automatic logic [255:0] sip_init();
      return {K0 ^ 64'h736f6d6570736575, K1 ^ 64'h646f72616e646f6d,
              K0 ^ 64'h6c7967656e657261, K1 ^ 64'h7465646279746573};
   endfunction

   function automatic logic [255:0] sip_comp(input logic [255:0] v, input logic [63:0] m);
      logic [255:0] t;
      t = v;
      t[63:0] ^= m;
      t = sip_rounds(t, 2);
      t[255:192] ^= m;
      return t;
   endfunction

   function automatic logic [63:0] sip_fin(input logic [255:0] v);
      logic [255:0] t;
      t = v;
      t[127:64] ^= 64'hff;
      t = sip_rounds(t, 4);
      return t[255:192] ^ t[191:128] ^ t[127:64] ^ t[63:0];
   endfunction

   // Core model + scoreboard pop; ready drops right after compress/finalize.
   always @(negedge clk) begin
      if (core_initalize || core_compress || core_finalize)
         check_val("strobe_rdy", 64'(core_ready), 64'd1);
      if (core_initalize) sv <= sip_init();
      if (core_compress) begin
         check_val("rdy_in_comp", 64'(in_ready), 64'd0);
         check_val("word_q_nonempty", 64'(exp_words.size() != 0), 64'd1);
         if (exp_words.size() != 0) check_val("word", core_mi, exp_words.pop_front());
         sv <= sip_comp(sv, core_mi);
      end
      if (core_finalize) core_res <= sip_fin(sv);
      if (core_compress || core_finalize) begin
         core_ready <= 1'b0;
         lat <= stall ? int'($urandom_range(1, 6)) : lat_fix;
      end else if (!core_ready) begin
         if (lat <= 1) core_ready <= 1'b1;
         else          lat <= lat - 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_expected(input int n);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < n; i++) begin
         w[8*(i%8) +: 8] = msg[i];
         if (i % 8 == 7) begin
            exp_words.push_back(w);
            w = '0;
         end
      end
      w[63:56] = n[7:0];
      exp_words.push_back(w);
   endtask

   task automatic do_start(input int n);
      @(negedge clk);
      start = 1'b1;
      empty_msg = (n == 0);
      @(negedge clk);
      start = 1'b0;
      empty_msg = 1'b0;
      check_val("init_c1", 64'(core_initalize), 64'd1);
      check_val("busy_c1", 64'(busy), 64'd1);
   endtask

   task automatic stream(input int n, input bit gaps, input bit last_en, input bit poke);
      int idx, cyc;
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check_val("rdy_c2", 64'(in_ready), 64'd1);
         in_valid  = !gaps || ($urandom_range(0, 3) != 0);
         in_data   = msg[idx];
         in_last   = last_en && (idx == n - 1);
         start     = poke && (idx == 3);
         empty_msg = start;
         if (in_valid && in_ready) idx++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      start     = 1'b0;
      empty_msg = 1'b0;
      check_val("stream_to", 64'(idx), 64'(n));
   endtask

   task automatic wait_done(input int d0);
      int cyc;
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      check_val("done_once", 64'(done_cnt - d0), 64'd1);
      check_val("done_pulse", 64'(done), 64'd0);
      check_val("busy_end", 64'(busy), 64'd0);
      check_val("words_left", 64'(exp_words.size()), 64'd0);
   endtask

   task automatic run_msg(input int n, input bit gaps, input bit poke);
      int d0;
      d0 = done_cnt;
      push_expected(n);
      do_start(n);
      if (n == 0) begin
         @(negedge clk);
         check_val("comp_c2", 64'(core_compress), 64'd1);
      end else begin
         stream(n, gaps, 1'b1, poke);
      end
      wait_done(d0);
   endtask

   task automatic wait_core_ready();
      int cyc;
      cyc = 0;
      while (!core_ready && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check_val("core_rdy_wait", 64'(core_ready), 64'd1);
   endtask

   initial begin
      int d0;
      areset    = 1'b1;
      start     = 1'b0;
      empty_msg = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      stall     = 1'b0;
      lat_fix   = 2;
`ifdef SIPHASH_FMT_ABORT_EN
      abort     = 1'b0;
`endif
      for (int i = 0; i < 300; i++) msg[i] = 8'(i);
      repeat (3) @(negedge clk);
      check_val("rst_outs", 64'({in_ready, core_initalize, core_compress, core_finalize, busy, done}), 64'd0);
      check_val("rst_mi", core_mi, 64'd0);
      areset = 1'b0;

      run_msg(0, 1'b0, 1'b0);
      check_val("hash_empty", core_res, 64'h726fdb47dd0e0e31);
      run_msg(15, 1'b0, 1'b0);
      check_val("hash_15", core_res, 64'ha129ca6149be45e5);
      run_msg(8, 1'b1, 1'b1);

      for (int i = 0; i < 300; i++) msg[i] = 8'($urandom);
      stall = 1'b1;
      run_msg(300, 1'b1, 1'b0);
      stall = 1'b0;

      // Asynchronous reset while waiting on the core after the first word.
      for (int i = 0; i < 300; i++) msg[i] = 8'(i);
      lat_fix = 8;
      push_expected(8);
      do_start(8);
      stream(8, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check_val("cw_busy", 64'(busy), 64'd1);
      areset = 1'b1;
      #1;
      check_val("arst_outs", 64'({in_ready, core_initalize, core_compress, core_finalize, busy, done}), 64'd0);
      check_val("arst_mi", core_mi, 64'd0);
      exp_words.delete();
      @(negedge clk);
      areset = 1'b0;
      wait_core_ready();
      lat_fix = 2;
      run_msg(15, 1'b0, 1'b0);
      check_val("hash_after_rst", core_res, 64'ha129ca6149be45e5);

`ifdef SIPHASH_FMT_ABORT_EN
      // Abort while collecting: core idle, so the formatter returns at once.
      d0 = done_cnt;
      do_start(3);
      stream(3, 1'b0, 1'b0, 1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_col_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      check_val("abort_col_done", 64'(done_cnt - d0), 64'd0);
      check_val("abort_col_rdy", 64'(in_ready), 64'd0);

      // Abort while the core is busy: busy holds until the core drains.
      lat_fix = 6;
      d0 = done_cnt;
      push_expected(8);
      void'(exp_words.pop_back());
      do_start(8);
      stream(8, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_cw_busy", 64'(busy), 64'd1);
      wait_core_ready();
      repeat (2) @(negedge clk);
      check_val("abort_cw_idle", 64'(busy), 64'd0);
      check_val("abort_cw_done", 64'(done_cnt - d0), 64'd0);
      check_val("abort_words_left", 64'(exp_words.size()), 64'd0);
      lat_fix = 2;
`else
      d0 = done_cnt;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/siphash_msg_formatter.md
# siphash_msg_formatter

Upstream feeder for `siphash_core`. Accepts a message as a byte stream, packs the bytes little-endian into 64-bit words, and appends the SipHash length byte plus zero padding. It then sequences the core's `initalize`/`compress`/`finalize` strobes against the core's `ready`, so the core is fully driven by one byte stream per hash.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a new hash; ignored unless `busy`=0.
- `empty_msg`  in  1  sampled with `start`; 1 = zero-length message.
- `in_valid`  in  1  byte valid.
- `in_data`  in  8  message byte.
- `in_last`  in  1  qualifies the final byte of the message.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `core_initalize`  out  1  single-cycle strobe to the core.
- `core_compress`  out  1  single-cycle strobe to the core.
- `core_finalize`  out  1  single-cycle strobe to the core.
- `core_mi`  out  64  message word; valid in the cycle `core_compress`=1.
- `core_ready`  in  1  core `ready`.
- `busy`  out  1  hash in progress.
- `done`  out  1  one-cycle pulse when the core has completed finalization.
- `abort`  in  1  present only with `SIPHASH_FMT_ABORT_EN`.

## Operation
- FSM states: IDLE, INIT, COLLECT, COMP, COMP_WAIT, FINAL, FINAL_WAIT.
- IDLE:
  - On `start`, go to INIT, set `busy`=1, clear the length counter and byte buffer, and latch `empty_msg`.
- INIT:
  - Assert `core_initalize` for 1 cycle.
  - If `empty_msg`=1, build a pad word of 0 and go to COMP with `last_word`=1.
  - Otherwise go to COLLECT.
- COLLECT:
  - `in_ready`=1.
  - An accepted byte is written to buffer lane `byte_ctr` (bits `8*k+7:8*k`). `byte_ctr` (3 bits) increments, and `msg_len` (8 bits) increments modulo 256.
  - 8th byte accepted, `in_last`=0: go to COMP with the full word, `last_word`=0.
  - 8th byte accepted, `in_last`=1: go to COMP with the full word and set `pad_pending`=1. The next word is `{msg_len,56'h0}`.
  - `in_last` with fewer than 8 bytes: word = `{msg_len_after_accept, buffer[55:0]}` with unwritten lanes zero; `last_word`=1.
  - `in_last` without `in_valid` has no effect.
- COMP:
  - Assert `core_compress` with `core_mi`=word, for exactly 1 cycle. Go to COMP_WAIT.
- COMP_WAIT:
  - Wait for `core_ready`=1.
  - If `pad_pending`: load the pad word, clear `pad_pending`, set `last_word`, go to COMP.
  - Else if `last_word`: go to FINAL.
  - Else: clear `byte_ctr` and the buffer, go to COLLECT.
- FINAL:
  - Assert `core_finalize` for 1 cycle. Go to FINAL_WAIT.
- FINAL_WAIT:
  - Wait for `core_ready`=1, then pulse `done`, set `busy`=0, go to IDLE.
- Length is carried only modulo 256; messages longer than 255 bytes wrap silently, as the algorithm specifies.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values: `in_ready`=0, `core_initalize`=0, `core_compress`=0, `core_finalize`=0, `core_mi`=0, `busy`=0, `done`=0. FSM resets to IDLE; counters and buffer reset to 0.
- `start` sampled at edge 0: `core_initalize` is high in cycle 1, and `in_ready` goes high in cycle 2.
- Byte accepted at edge t that completes a word: `core_compress` is high in cycle t+1, and `in_ready`=0 from cycle t+1 until re-entry to COLLECT.
- The core drops `ready` in the cycle after `compress`/`finalize`. COMP_WAIT and FINAL_WAIT therefore never observe a stale `ready`=1, and no guard cycle is required.
- Within COMP_WAIT/FINAL_WAIT, the action follows the first cycle in which `core_ready`=1 by exactly one cycle.
- All outputs are registered.

## Configuration
- `SIPHASH_FMT_ABORT_EN` defined:
  - The `abort` input exists.
  - `abort`=1 in any non-IDLE state clears the buffer, counters and flags, and forces `in_ready`=0 and all strobes to 0.
  - If the core is busy (`core_ready`=0), the FSM goes to FINAL_WAIT-style drain and waits for `core_ready`=1 with no `done` pulse. Otherwise it goes to IDLE with `busy`=0 next cycle.
  - `abort` beats `start` in the same cycle.
- `SIPHASH_FMT_ABORT_EN` not defined: no `abort` port, and the FSM has no abort paths.

## Structure
- Shared package `siphash_pkg`:
  - FSM state encoding constants.
  - `SIPHASH_WORD_BYTES`=8.
  - Length-byte lane position 7.
- Sub-module `siphash_byte_packer`: 64-bit buffer, `byte_ctr`, `msg_len`, and pad-word generation. It takes clear, write-byte and form-pad controls from the FSM.

## Test plan
- Key 00..0f, 2/4 rounds, `start` with `empty_msg`=1: a single compress with `core_mi`=0, then finalize. Core result = 64'h726fdb47dd0e0e31.
- 15 bytes 00..0e:
  - Compresses 64'h0706050403020100, then 64'h0f0e0d0c0b0a0908.
  - Then finalize; result 64'ha129ca6149be45e5.
- 8 bytes 00..07: compresses 64'h0706050403020100, then 64'h0800000000000000; the `pad_pending` path.
- 300-byte message with random `in_valid` gaps and a stalled model core: word boundaries are correct, the final length byte = 8'h2c, and no strobe is asserted while `core_ready`=0.
- `start` pulsed while `busy`: ignored. `areset` asserted mid-COMP_WAIT: all outputs return to reset values immediately, and the next `start` produces a correct hash.
- With `SIPHASH_FMT_ABORT_EN`:
  - `abort` in COLLECT after 3 bytes: `busy` falls next cycle, with no `done`.
  - `abort` in COMP_WAIT: `busy` stays 1 until `core_ready`=1, with no `done`.
